// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU fetch-stage definitions: controller state encoding, next-PC
// select codes and the default reset/interrupt vectors.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_DISCARD,
    ST_INT,
    ST_HALT
  } fetch_state_t;

  typedef enum logic [1:0] {
    NPC_HOLD,
    NPC_INC,
    NPC_LOAD
  } npc_sel_t;

  localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
  localparam logic [15:0] DEF_INT_VEC   = 16'h0004;

endpackage

// File: rtl/fetch_ctrl_next_pc_sel.sv
// Next-address selection for the pc register: hold, increment (16-bit wrap)
// or load of an explicit address through the register's load port.
module next_pc_sel
  import fetch_ctrl_pkg::*;
(
  input  logic [15:0] pc,
  input  npc_sel_t    sel,
  input  logic [15:0] load_addr,
  output logic [15:0] addr_in,
  output logic        pc_rst,
  output logic [15:0] pc_rst_addr
);

  always_comb begin
    addr_in     = pc;
    pc_rst      = 1'b0;
    pc_rst_addr = load_addr;
    case (sel)
      NPC_INC:  addr_in = pc + 16'd1;
      NPC_LOAD: pc_rst  = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the external pc register, runs the
// instruction-memory handshake, and sequences branches, interrupts and halt.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [15:0] INT_VEC   = DEF_INT_VEC
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] PcIn,
  output logic [15:0] AddrIn,
  output logic        PcRst,
  output logic [15:0] PcRstAddr,
  output logic        MemReq,
  output logic [15:0] MemAddr,
  input  logic        MemAck,
  input  logic [15:0] MemData,
  output logic [15:0] InstrOut,
  output logic        InstrValid,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [15:0] BranchTarget,
  input  logic        Halt,
  input  logic        IntReq,
  input  logic        IntEn,
  output logic        IntAck,
  output logic [15:0] EpcOut
);

  fetch_state_t state, state_n;
  logic         pending;
  logic [15:0]  saved_tgt;
  logic         int_ok, halt_ok, fetch_done, save_tgt;
  npc_sel_t     sel;
  logic [15:0]  load_addr;

  assign MemAddr = PcIn;

  always_comb begin
    int_ok     = IntReq & IntEn & ~pending;
    halt_ok    = Halt & ~pending;
    MemReq     = 1'b0;
    state_n    = state;
    sel        = NPC_HOLD;
    load_addr  = RESET_VEC;
    fetch_done = 1'b0;
    save_tgt   = 1'b0;
    if (Rst) begin
      sel     = NPC_LOAD;
      state_n = ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          // An outstanding request is never withdrawn; events only block new issue.
          MemReq = pending | ~(Stall | BranchTaken | int_ok | halt_ok);
          if (BranchTaken) begin
            if (pending & ~MemAck) begin
              save_tgt = 1'b1;
              state_n  = ST_DISCARD;
            end else begin
              sel       = NPC_LOAD;
              load_addr = BranchTarget;
            end
          end else if (int_ok) begin
            state_n = ST_INT;
          end else if (halt_ok) begin
            state_n = ST_HALT;
          end else if (MemReq & MemAck) begin
            sel        = NPC_INC;
            fetch_done = 1'b1;
          end
        end
        ST_DISCARD: begin
          MemReq   = 1'b1;
          save_tgt = BranchTaken;
          if (MemAck) begin
            sel       = NPC_LOAD;
            load_addr = BranchTaken ? BranchTarget : saved_tgt;
            state_n   = ST_FETCH;
          end
        end
        ST_INT: begin
          sel       = NPC_LOAD;
          load_addr = INT_VEC;
          state_n   = ST_FETCH;
        end
        ST_HALT: begin
          if (IntReq & IntEn) state_n = ST_INT;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= ST_FETCH;
      pending    <= 1'b0;
      saved_tgt  <= '0;
      InstrOut   <= '0;
      InstrValid <= 1'b0;
      IntAck     <= 1'b0;
      EpcOut     <= '0;
    end else begin
      state      <= state_n;
      pending    <= MemReq & ~MemAck;
      InstrValid <= fetch_done;
      IntAck     <= (state == ST_INT);
      if (fetch_done)        InstrOut  <= MemData;
      if (state == ST_INT)   EpcOut    <= PcIn;
      if (save_tgt)          saved_tgt <= BranchTarget;
    end
  end

  next_pc_sel u_next_pc_sel (
    .pc          (PcIn),
    .sel         (sel),
    .load_addr   (load_addr),
    .addr_in     (AddrIn),
    .pc_rst      (PcRst),
    .pc_rst_addr (PcRstAddr)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl with a pc register and instruction memory around it;
// directed scenarios plus a randomized run against a program-order model.
module tb_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Rst, MemAck, Stall, BranchTaken, Halt, IntReq, IntEn;
  logic [15:0] MemData, BranchTarget, pc;
  logic [15:0] AddrIn, PcRstAddr, MemAddr, InstrOut, EpcOut;
  logic        PcRst, MemReq, InstrValid, IntAck;

  int checks = 0;
  int errors = 0;
  int ack_mode, ack_delay, wait_cnt;

  logic        ob_req, ob_ack, ob_valid, ob_intack, ob_pcrst;
  logic [15:0] ob_addr, ob_iout, ob_epc, ob_pcrstaddr;

  fetch_ctrl #(.RESET_VEC(16'h0000), .INT_VEC(16'h0004)) dut (
    .Clk(Clk), .Rst(Rst), .PcIn(pc), .AddrIn(AddrIn), .PcRst(PcRst),
    .PcRstAddr(PcRstAddr), .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck),
    .MemData(MemData), .InstrOut(InstrOut), .InstrValid(InstrValid),
    .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Halt(Halt), .IntReq(IntReq), .IntEn(IntEn), .IntAck(IntAck), .EpcOut(EpcOut)
  );

  always #5 Clk = ~Clk;

  // The pc register the controller steers.
  always_ff @(posedge Clk) pc <= PcRst ? PcRstAddr : AddrIn;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Called at a falling edge with this cycle's inputs already set.
  task automatic tick();
    #1;
    MemData = mdata(MemAddr);
    case (ack_mode)
      0:       MemAck = 1'b0;
      1:       MemAck = 1'b1;
      2:       MemAck = MemReq & ($urandom_range(0, 1) == 1);
      default: MemAck = MemReq && (wait_cnt >= ack_delay);
    endcase
    if (MemReq && !MemAck) wait_cnt++;
    else if (MemAck)       wait_cnt = 0;
    #1;
    ob_req = MemReq; ob_ack = MemAck; ob_addr = MemAddr; ob_valid = InstrValid;
    ob_iout = InstrOut; ob_intack = IntAck; ob_epc = EpcOut;
    ob_pcrst = PcRst; ob_pcrstaddr = PcRstAddr;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic goto_pc(input logic [15:0] a);
    ack_mode = 1; Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = a;
    tick();
    BranchTaken = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Rst = 1'b1; tick(); tick();
    checks++; if (ob_req !== 1'b0) begin errors++; $display("FAIL rst_memreq got %b want 0", ob_req); end
    checks++; if (ob_pcrst !== 1'b1) begin errors++; $display("FAIL rst_pcrst got %b want 1", ob_pcrst); end
    checks++; if (ob_pcrstaddr !== 16'h0000) begin errors++; $display("FAIL rst_pcrstaddr got %h want 0000", ob_pcrstaddr); end
    checks++; if (ob_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", ob_valid); end
    checks++; if (ob_iout !== 16'h0000) begin errors++; $display("FAIL rst_instr got %h want 0000", ob_iout); end
    checks++; if (ob_intack !== 1'b0) begin errors++; $display("FAIL rst_intack got %b want 0", ob_intack); end
    checks++; if (ob_epc !== 16'h0000) begin errors++; $display("FAIL rst_epc got %h want 0000", ob_epc); end
    Rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [15:0] ea;
    Rst = 1'b1; ack_mode = 1; tick(); Rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ea = 16'(k);
      tick();
      checks++; if (ob_req !== 1'b1 || ob_addr !== ea) begin errors++; $display("FAIL seq_req[%0d] got %b/%h want 1/%h", k, ob_req, ob_addr, ea); end
      checks++; if (ob_valid !== (k > 0)) begin errors++; $display("FAIL seq_valid[%0d] got %b want %b", k, ob_valid, k > 0); end
      if (k > 0) begin
        checks++; if (ob_iout !== mdata(ea - 16'd1)) begin errors++; $display("FAIL seq_instr[%0d] got %h want %h", k, ob_iout, mdata(ea - 16'd1)); end
      end
    end
  endtask

  task automatic test_ack_delay();
    int nvalid = 0;
    goto_pc(16'h0010);
    ack_mode = 3; ack_delay = 3; wait_cnt = 0; Stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      Stall = 1'b1;
      checks++; if (ob_req !== 1'b1 || ob_addr !== 16'h0010) begin errors++; $display("FAIL delay_req[%0d] got %b/%h want 1/0010", k, ob_req, ob_addr); end
      if (ob_valid === 1'b1) nvalid++;
    end
    tick();
    checks++; if (nvalid != 0 || ob_valid !== 1'b1) begin errors++; $display("FAIL delay_valid early %0d final %b want 0/1", nvalid, ob_valid); end
    checks++; if (ob_iout !== mdata(16'h0010)) begin errors++; $display("FAIL delay_instr got %h want %h", ob_iout, mdata(16'h0010)); end
    checks++; if (ob_addr !== 16'h0011 || ob_req !== 1'b0) begin errors++; $display("FAIL delay_next got %h/%b want 0011/0", ob_addr, ob_req); end
    tick();
    checks++; if (ob_valid !== 1'b0) begin errors++; $display("FAIL delay_pulse got %b want 0", ob_valid); end
  endtask

  task automatic test_branch_discard();
    goto_pc(16'h0020);
    ack_mode = 0; Stall = 1'b0;
    tick(); tick();
    checks++; if (ob_req !== 1'b1 || ob_addr !== 16'h0020) begin errors++; $display("FAIL disc_req got %b/%h want 1/0020", ob_req, ob_addr); end
    BranchTaken = 1'b1; BranchTarget = 16'h0100;
    tick();
    checks++; if (ob_req !== 1'b1 || ob_pcrst !== 1'b0) begin errors++; $display("FAIL disc_hold got %b/%b want 1/0", ob_req, ob_pcrst); end
    BranchTaken = 1'b0;
    tick();
    checks++; if (ob_req !== 1'b1 || ob_addr !== 16'h0020 || ob_valid !== 1'b0) begin errors++; $display("FAIL disc_wait got %b/%h/%b want 1/0020/0", ob_req, ob_addr, ob_valid); end
    ack_mode = 1;
    tick();
    checks++; if (ob_pcrst !== 1'b1 || ob_pcrstaddr !== 16'h0100) begin errors++; $display("FAIL disc_load got %b/%h want 1/0100", ob_pcrst, ob_pcrstaddr); end
    tick();
    checks++; if (ob_req !== 1'b1 || ob_addr !== 16'h0100 || ob_valid !== 1'b0) begin errors++; $display("FAIL disc_drop got %b/%h/%b want 1/0100/0", ob_req, ob_addr, ob_valid); end
    tick();
    checks++; if (ob_valid !== 1'b1 || ob_iout !== mdata(16'h0100)) begin errors++; $display("FAIL disc_target got %b/%h want 1/%h", ob_valid, ob_iout, mdata(16'h0100)); end
  endtask

  task automatic test_interrupt();
    goto_pc(16'h0030);
    IntReq = 1'b1; IntEn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (ob_intack !== 1'b0 || ob_pcrst !== 1'b0 || ob_addr !== 16'h0030) begin errors++; $display("FAIL int_masked[%0d] got %b/%b/%h want 0/0/0030", k, ob_intack, ob_pcrst, ob_addr); end
    end
    IntEn = 1'b1;
    tick();
    IntReq = 1'b0;
    tick();
    checks++; if (ob_pcrst !== 1'b1 || ob_pcrstaddr !== 16'h0004) begin errors++; $display("FAIL int_vec got %b/%h want 1/0004", ob_pcrst, ob_pcrstaddr); end
    Stall = 1'b0; ack_mode = 1;
    tick();
    checks++; if (ob_intack !== 1'b1 || ob_epc !== 16'h0030) begin errors++; $display("FAIL int_ack got %b/%h want 1/0030", ob_intack, ob_epc); end
    checks++; if (ob_req !== 1'b1 || ob_addr !== 16'h0004) begin errors++; $display("FAIL int_fetch got %b/%h want 1/0004", ob_req, ob_addr); end
    tick();
    checks++; if (ob_intack !== 1'b0) begin errors++; $display("FAIL int_pulse got %b want 0", ob_intack); end
    IntEn = 1'b0;
  endtask

  task automatic test_branch_vs_int();
    goto_pc(16'h0060);
    IntReq = 1'b1; IntEn = 1'b1; BranchTaken = 1'b1; BranchTarget = 16'h0070;
    tick();
    checks++; if (ob_pcrst !== 1'b1 || ob_pcrstaddr !== 16'h0070) begin errors++; $display("FAIL prio_branch got %b/%h want 1/0070", ob_pcrst, ob_pcrstaddr); end
    BranchTaken = 1'b0;
    tick();
    IntReq = 1'b0;
    tick();
    checks++; if (ob_pcrst !== 1'b1 || ob_pcrstaddr !== 16'h0004) begin errors++; $display("FAIL prio_int got %b/%h want 1/0004", ob_pcrst, ob_pcrstaddr); end
    IntEn = 1'b0;
    tick();
    checks++; if (ob_intack !== 1'b1 || ob_epc !== 16'h0070) begin errors++; $display("FAIL prio_epc got %b/%h want 1/0070", ob_intack, ob_epc); end
  endtask

  task automatic test_halt();
    goto_pc(16'h0040);
    Stall = 1'b0; Halt = 1'b1;
    tick();
    Halt = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (ob_req !== 1'b0 || ob_addr !== 16'h0040) begin errors++; $display("FAIL halt_idle[%0d] got %b/%h want 0/0040", k, ob_req, ob_addr); end
    end
    IntReq = 1'b1; IntEn = 1'b1;
    tick();
    IntReq = 1'b0;
    tick();
    tick();
    checks++; if (ob_intack !== 1'b1 || ob_epc !== 16'h0040) begin errors++; $display("FAIL halt_epc got %b/%h want 1/0040", ob_intack, ob_epc); end
    checks++; if (ob_req !== 1'b1 || ob_addr !== 16'h0004) begin errors++; $display("FAIL halt_resume got %b/%h want 1/0004", ob_req, ob_addr); end
    IntEn = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    goto_pc(16'hFFFF);
    Stall = 1'b0;
    tick();
    tick();
    checks++; if (ob_addr !== 16'h0000 || ob_valid !== 1'b1 || ob_iout !== mdata(16'hFFFF)) begin errors++; $display("FAIL wrap got %h/%b/%h want 0000/1/%h", ob_addr, ob_valid, ob_iout, mdata(16'hFFFF)); end
    goto_pc(16'h0050);
    ack_mode = 0; Stall = 1'b0;
    tick(); tick();
    checks++; if (ob_req !== 1'b1 || ob_addr !== 16'h0050) begin errors++; $display("FAIL rstmid_req got %b/%h want 1/0050", ob_req, ob_addr); end
    Rst = 1'b1;
    tick();
    checks++; if (ob_req !== 1'b0 || ob_pcrst !== 1'b1 || ob_pcrstaddr !== 16'h0000) begin errors++; $display("FAIL rstmid_abort got %b/%b/%h want 0/1/0000", ob_req, ob_pcrst, ob_pcrstaddr); end
    Rst = 1'b0; ack_mode = 1;
    tick();
    checks++; if (ob_req !== 1'b1 || ob_addr !== 16'h0000 || ob_valid !== 1'b0) begin errors++; $display("FAIL rstmid_restart got %b/%h/%b want 1/0000/0", ob_req, ob_addr, ob_valid); end
    tick();
    checks++; if (ob_valid !== 1'b1 || ob_iout !== mdata(16'h0000)) begin errors++; $display("FAIL rstmid_first got %b/%h want 1/%h", ob_valid, ob_iout, mdata(16'h0000)); end
  endtask

  // Program-order model: each delivered instruction is the one after the
  // previous, and a branch redirects the stream to its target.
  task automatic test_random();
    logic [15:0] exp_pc, prev_addr;
    logic        prev_out;
    int          nvalid = 0;
    goto_pc(16'h0200);
    exp_pc = 16'h0200; prev_out = 1'b0; prev_addr = '0;
    ack_mode = 2;
    for (int i = 0; i < 400; i++) begin
      Stall        = ($urandom_range(0, 9) < 3);
      BranchTaken  = ($urandom_range(0, 11) == 0);
      BranchTarget = 16'($urandom);
      tick();
      if (prev_out) begin
        checks++; if (ob_req !== 1'b1 || ob_addr !== prev_addr) begin errors++; $display("FAIL rnd_hold[%0d] got %b/%h want 1/%h", i, ob_req, ob_addr, prev_addr); end
      end else begin
        checks++; if (ob_req !== (!Stall && !BranchTaken)) begin errors++; $display("FAIL rnd_issue[%0d] got %b want %b", i, ob_req, !Stall && !BranchTaken); end
      end
      if (ob_valid === 1'b1) begin
        checks++; if (ob_iout !== mdata(exp_pc)) begin errors++; $display("FAIL rnd_instr[%0d] got %h want %h", i, ob_iout, mdata(exp_pc)); end
        exp_pc = exp_pc + 16'd1;
        nvalid++;
      end
      if (BranchTaken) exp_pc = BranchTarget;
      prev_out  = ob_req && !ob_ack;
      prev_addr = ob_addr;
    end
    checks++; if (nvalid < 50) begin errors++; $display("FAIL rnd_progress got %0d want >=50", nvalid); end
    Stall = 1'b0; BranchTaken = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; MemAck = 1'b0; MemData = '0; Stall = 1'b0; BranchTaken = 1'b0;
    BranchTarget = '0; Halt = 1'b0; IntReq = 1'b0; IntEn = 1'b0;
    ack_mode = 0; ack_delay = 0; wait_cnt = 0;
    @(negedge Clk);
    test_reset();
    test_sequential();
    test_ack_delay();
    test_branch_discard();
    test_interrupt();
    test_branch_vs_int();
    test_halt();
    test_wrap_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "timeout");
  end

endmodule
